// File: rtl/fetch_ctrl.sv
// Fetch-stage controller and fetch/decode pipeline register.
// Owns the PC, talks to a stalling imem, feeds one instruction per cycle.
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imemRd,
    output logic [15:0] imemAddr,
    input  logic [15:0] imemData,
    input  logic        imemDone,
    input  logic        stallD,
    input  logic        redirectX,
    input  logic [15:0] redirectPCX,
    output logic [15:0] instructionD,
    output logic [15:0] incPCD,
    output logic        validD,
    output logic        haltedF
);

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] WAIT   = 3'd1;
    localparam logic [2:0] HOLD   = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] HALTED = 3'd4;

    logic [2:0]  state;
    logic [15:0] pc;
    logic [15:0] drain_addr;
    logic [15:0] buf_instr;
    logic [15:0] buf_inc;
    logic [15:0] pc_inc;
    logic [15:0] target;
    logic        data_halt;
    logic        buf_halt;

    // Request, address and decode helpers
    always_comb begin
        imemRd    = ((state == FETCH) && !stallD) ||
                    (state == WAIT) || (state == DRAIN);
        imemAddr  = (state == DRAIN) ? drain_addr : pc;
        pc_inc    = pc + 16'd2;
        target    = redirectPCX & 16'hFFFE;
        data_halt = (imemData[15:11] == 5'b00000);
        buf_halt  = (buf_instr[15:11] == 5'b00000);
        haltedF   = (state == HALTED);
    end

    // FSM, PC, skid buffer and decode register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            drain_addr   <= RESET_PC;
            buf_instr    <= 16'h0000;
            buf_inc      <= 16'h0000;
            instructionD <= NOP_INSTR;
            incPCD       <= 16'h0000;
            validD       <= 1'b0;
        end else begin
            // Old address is kept for draining after a redirect
            if (state != DRAIN) begin
                drain_addr <= pc;
            end
            if (redirectX) begin
                pc           <= target;
                instructionD <= NOP_INSTR;
                validD       <= 1'b0;
                buf_instr    <= 16'h0000;
                buf_inc      <= 16'h0000;
                if (((state == WAIT) || (state == DRAIN)) && !imemDone) begin
                    state <= DRAIN;
                end else begin
                    state <= FETCH;
                end
            end else begin
                case (state)
                    FETCH: begin
                        if (!stallD) begin
                            if (imemDone) begin
                                instructionD <= imemData;
                                incPCD       <= pc_inc;
                                validD       <= 1'b1;
                                pc           <= pc_inc;
                                state        <= data_halt ? HALTED : FETCH;
                            end else begin
                                state <= WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        if (imemDone) begin
                            pc <= pc_inc;
                            if (stallD) begin
                                buf_instr <= imemData;
                                buf_inc   <= pc_inc;
                                state     <= HOLD;
                            end else begin
                                instructionD <= imemData;
                                incPCD       <= pc_inc;
                                validD       <= 1'b1;
                                state        <= data_halt ? HALTED : FETCH;
                            end
                        end
                    end
                    HOLD: begin
                        if (!stallD) begin
                            instructionD <= buf_instr;
                            incPCD       <= buf_inc;
                            validD       <= 1'b1;
                            state        <= buf_halt ? HALTED : FETCH;
                        end
                    end
                    DRAIN: begin
                        if (imemDone) begin
                            state <= FETCH;
                        end
                    end
                    HALTED: begin
                        if (!stallD) begin
                            instructionD <= NOP_INSTR;
                            validD       <= 1'b0;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

endmodule
